barrel_rotator_pipe: RTL

//  Parametrised, pipelined barrel shifter/rotator; successor to the 4-bit mux-based left rotator.

---
 rtl/barrel_rotator_pipe.sv | 78 +++++++
 1 files changed

// File: rtl/barrel_rotator_pipe.sv
// barrel_rotator_pipe: pipelined rotl/rotr/shl/shr with one log2 shift stage per register and valid/ready backpressure
// Optional out_zero flag is enabled by defining BRP_ZERO_FLAG_EN.
module barrel_rotator_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_k,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BRP_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);
  logic             adv;
  logic [SHW-1:0]   v, pv;
  logic [WIDTH-1:0] d [SHW];
  logic [WIDTH-1:0] pd [SHW];
  logic [WIDTH-1:0] nd [SHW];
  logic [SHW-1:0]   k [SHW];
  logic [SHW-1:0]   pk [SHW];
  logic [1:0]       o [SHW];
  logic [1:0]       po [SHW];
  logic             unused;
  function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] x, input logic [1:0] op, input int a);
    return op == 2'b00 ? (x << a) | (x >> (WIDTH - a)) :
           op == 2'b01 ? (x >> a) | (x << (WIDTH - a)) :
           op == 2'b10 ? x << a : x >> a;
  endfunction
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[SHW-1];
  assign out_data  = d[SHW-1];
  // the last stage's k/op have no further consumer
  assign unused    = ^{k[SHW-1], o[SHW-1]};
  always_comb begin
    pv[0] = in_valid;
    pd[0] = in_data;
    pk[0] = in_k;
    po[0] = in_op;
    for (int s = 1; s < SHW; s++) begin
      pv[s] = v[s-1];
      pd[s] = d[s-1];
      pk[s] = k[s-1];
      po[s] = o[s-1];
    end
    for (int s = 0; s < SHW; s++)
      nd[s] = pk[s][s] ? shf(pd[s], po[s], 1 << s) : pd[s];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int s = 0; s < SHW; s++) begin
        d[s] <= '0;
        k[s] <= '0;
        o[s] <= '0;
      end
    end else if (adv) begin
      v <= pv;
      for (int s = 0; s < SHW; s++) begin
        d[s] <= nd[s];
        k[s] <= pk[s];
        o[s] <= po[s];
      end
    end
`ifdef BRP_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_zero <= 1'b0;
    else if (adv) out_zero <= nd[SHW-1] == '0;
`endif
endmodule
